pc_fetch_unit: RTL

Instruction-fetch and PC sequencing stage that sits directly upstream of the instruction decoder and control unit. It holds the PC and fetches one 16-bit instruction per instruction over a req/rdy handshake with instruction memory. It presents the instruction for one execute cycle, then consumes the control outputs PCWrite, Branch and BrReg to choose the next PC or to halt. The memory may have variable latency, which prepares the datapath for a cached/multi-cycle memory.

---
 rtl/pc_fetch_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch and PC sequencing stage.
// Fetches one 16-bit instruction per instruction over a req/rdy handshake,
// presents it for a single execute cycle, then picks the next PC from the
// control inputs (sequential, PC-relative branch, register-indirect branch)
// or halts. The optional fetch-wait timeout is enabled by defining the
// macro FETCH_TIMEOUT_EN; without it FETCH waits indefinitely.
module pc_fetch_unit #(
    parameter logic [15:0] RESET_PC       = 16'h0000,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCWrite,
    input  logic        Branch,
    input  logic        BrReg,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_reg_val,
    input  logic        imem_rdy,
    input  logic [15:0] imem_data,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [15:0] pc_plus2,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] br_offset;
    logic        timeout_hit;

    // Word offset sign-extended and scaled to bytes; 6 + 9 + 1 = 16 bits.
    assign br_offset = {{6{imm9[8]}}, imm9, 1'b0};
    assign pc_plus2  = pc_q + 16'd2;

    // Outputs come straight from registered state, so reset clears them at once.
    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == EXEC);
    assign halted      = (state_q == HALT);

    // State, PC and instruction registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    // Next-state and next-PC selection.
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // A ready in the limit cycle still completes the fetch.
                if (imem_rdy) begin
                    instr_d = imem_data;
                    state_d = EXEC;
                end else if (timeout_hit) begin
                    state_d = HALT;
                end
            end
            EXEC: begin
                // Halt is checked first so Branch/BrReg may be unknown here.
                if (!PCWrite) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                    if (BrReg) begin
                        pc_d = br_reg_val;
                    end else if (Branch) begin
                        pc_d = pc_plus2 + br_offset;
                    end else begin
                        pc_d = pc_plus2;
                    end
                end
            end
            HALT: begin
                state_d = HALT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             fetch_err_q;

    // Limit is reached on the cycle whose stall would make the count TIMEOUT_CYCLES.
    assign timeout_hit = (state_q == FETCH) && !imem_rdy &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign fetch_err   = fetch_err_q;

    // Stall counter (zero whenever outside FETCH) and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            if (state_q != FETCH) begin
                wait_cnt_q <= '0;
            end else if (!imem_rdy) begin
                wait_cnt_q <= wait_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                fetch_err_q <= 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    // The limit has no effect in this build; this comparison is constant 0.
    assign fetch_err   = (TIMEOUT_CYCLES < 0);
`endif

endmodule
